// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states,
// forwarding-select codes and the register-match helper.
package hazard_ctrl_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   // x0 is hardwired to zero, so a write to it never creates a dependency.
   function automatic logic reg_hit(input logic              wr,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] src);
      return wr && (rd != '0) && (rd == src);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand bypass select for one EX source register: the youngest
// in-flight producer (MEM) wins over the older one (WB).
module fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] i_src,
   input  logic [REG_AW-1:0] i_rd_addr_m,
   input  logic              i_rd_wr_m,
   input  logic [REG_AW-1:0] i_rd_addr_w,
   input  logic              i_rd_wr_w,
   output logic [1:0]        o_sel
);

   always_comb begin
      if (reg_hit(i_rd_wr_m, i_rd_addr_m, i_src))
         o_sel = FWD_MEM;
      else if (reg_hit(i_rd_wr_w, i_rd_addr_w, i_src))
         o_sel = FWD_WB;
      else
         o_sel = FWD_RF;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait/halt FSM, mispredict flush,
// load-use bubble, operand forwarding and stall/flush performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1_addr_d,
   input  logic [REG_AW-1:0] rs2_addr_d,
   input  logic [REG_AW-1:0] rs1_addr_e,
   input  logic [REG_AW-1:0] rs2_addr_e,
   input  logic [REG_AW-1:0] rd_addr_e,
   input  logic              rd_wr_e,
   input  logic              mem_rd_e,
   input  logic [REG_AW-1:0] rd_addr_m,
   input  logic              rd_wr_m,
   input  logic              mem_req_m,
   input  logic              invalid_m,
   input  logic [REG_AW-1:0] rd_addr_w,
   input  logic              rd_wr_w,
   input  logic              mispredict_m,
   input  logic              dmem_ack,
   output logic              en_f,
   output logic              en_d,
   output logic              en_e,
   output logic              en_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              dmem_req,
   output logic              redirect,
   output logic              halted,
   output logic              mem_err,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   localparam int                WCNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

   state_e            r_state;
   logic [WCNT_W-1:0] r_wait_cnt;
   logic [31:0]       r_stall_cnt;
   logic [31:0]       r_flush_cnt;
   logic              r_mem_err;
   logic              r_halted;

   state_e            w_next_state;
   logic [3:0]        w_en;
   logic              w_flush_d;
   logic              w_flush_e;
   logic              w_flush_m;
   logic              w_redirect;
   logic              w_dmem_req;
   logic              w_timeout;
   logic              w_flow;
   logic              w_load_use;

   assign w_load_use = mem_rd_e && (reg_hit(rd_wr_e, rd_addr_e, rs1_addr_d) ||
                                    reg_hit(rd_wr_e, rd_addr_e, rs2_addr_d));

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      w_next_state = r_state;
      w_en         = 4'b1111;
      w_flush_d    = 1'b0;
      w_flush_e    = 1'b0;
      w_flush_m    = 1'b0;
      w_redirect   = 1'b0;
      w_dmem_req   = 1'b0;
      w_timeout    = 1'b0;
      w_flow       = 1'b0;

      unique case (r_state)
         RUN: begin
            if (invalid_m) begin
               w_en         = 4'b0000;
               w_next_state = HALT;
            end else if (mem_req_m && !dmem_ack) begin
               w_en         = 4'b0000;
               w_dmem_req   = 1'b1;
               w_next_state = MEM_WAIT;
            end else begin
               w_dmem_req = mem_req_m;
               w_flow     = 1'b1;
            end
         end
         MEM_WAIT: begin
            w_dmem_req = 1'b1;
            if (dmem_ack) begin
               // The ack cycle is an unstalled cycle: pending redirects are taken here.
               w_next_state = RUN;
               w_flow       = 1'b1;
            end else begin
               w_en = 4'b0000;
               if (r_wait_cnt == WAIT_LAST) begin
                  w_timeout    = 1'b1;
                  w_next_state = HALT;
               end
            end
         end
         HALT: begin
            w_en = 4'b0000;
         end
         default: begin
            w_en         = 4'b0000;
            w_next_state = RUN;
         end
      endcase

      if (w_flow) begin
         if (mispredict_m) begin
            w_flush_d  = 1'b1;
            w_flush_e  = 1'b1;
            w_flush_m  = 1'b1;
            w_redirect = 1'b1;
         end else if (w_load_use) begin
            w_en[3:2] = 2'b00;
            w_flush_e = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         r_state     <= RUN;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_mem_err   <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= (r_state == MEM_WAIT && w_next_state == MEM_WAIT) ?
                       r_wait_cnt + WCNT_W'(1) : '0;
         if (!w_en[3] && r_state != HALT)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_redirect)
            r_flush_cnt <= r_flush_cnt + 32'd1;
         if (w_timeout)
            r_mem_err <= 1'b1;
         r_halted <= (w_next_state == HALT);
      end
   end

   fwd_unit u_fwd_a (
      .i_src       (rs1_addr_e),
      .i_rd_addr_m (rd_addr_m),
      .i_rd_wr_m   (rd_wr_m),
      .i_rd_addr_w (rd_addr_w),
      .i_rd_wr_w   (rd_wr_w),
      .o_sel       (fwd_a_sel)
   );

   fwd_unit u_fwd_b (
      .i_src       (rs2_addr_e),
      .i_rd_addr_m (rd_addr_m),
      .i_rd_wr_m   (rd_wr_m),
      .i_rd_addr_w (rd_addr_w),
      .i_rd_wr_w   (rd_wr_w),
      .o_sel       (fwd_b_sel)
   );

   assign {en_f, en_d, en_e, en_m} = w_en;
   assign flush_d   = w_flush_d;
   assign flush_e   = w_flush_e;
   assign flush_m   = w_flush_m;
   assign redirect  = w_redirect;
   assign dmem_req  = w_dmem_req;
   assign halted    = r_halted;
   assign mem_err   = r_mem_err;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle expected control vectors go
// through a scoreboard queue; counters and status flags are checked inline.
module tb_hazard_ctrl;

   localparam int WAIT_MAX = 4;

   // Observed vector: {en_f,en_d,en_e,en_m, flush_d,flush_e,flush_m, redirect, dmem_req, fwd_a, fwd_b}
   localparam logic [12:0] E_RUN   = 13'b1111_000_0_0_00_00;
   localparam logic [12:0] E_ZW    = 13'b1111_000_0_1_00_00;
   localparam logic [12:0] E_MSTL  = 13'b0000_000_0_1_00_00;
   localparam logic [12:0] E_STOP  = 13'b0000_000_0_0_00_00;
   localparam logic [12:0] E_FLUSH = 13'b1111_111_1_0_00_00;
   localparam logic [12:0] E_AFL   = 13'b1111_111_1_1_00_00;
   localparam logic [12:0] E_LU    = 13'b0011_010_0_0_00_00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e, rd_addr_e, rd_addr_m, rd_addr_w;
   logic        rd_wr_e, mem_rd_e, rd_wr_m, mem_req_m, invalid_m, rd_wr_w, mispredict_m, dmem_ack;
   logic        en_f, en_d, en_e, en_m, flush_d, flush_e, flush_m, dmem_req, redirect, halted, mem_err;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [31:0] stall_cnt, flush_cnt;
   logic [12:0] obs;

   typedef struct {
      logic       rst_n;
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
      logic       rd_wr_e, mem_rd_e, rd_wr_m, mem_req_m, invalid_m, rd_wr_w, mispredict_m, dmem_ack;
   } stim_t;

   typedef struct {
      string       tag;
      logic [12:0] v;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   assign obs = {en_f, en_d, en_e, en_m, flush_d, flush_e, flush_m, redirect, dmem_req, fwd_a_sel, fwd_b_sel};

   hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
      .rs1_addr_e(rs1_addr_e), .rs2_addr_e(rs2_addr_e),
      .rd_addr_e(rd_addr_e), .rd_wr_e(rd_wr_e), .mem_rd_e(mem_rd_e),
      .rd_addr_m(rd_addr_m), .rd_wr_m(rd_wr_m), .mem_req_m(mem_req_m), .invalid_m(invalid_m),
      .rd_addr_w(rd_addr_w), .rd_wr_w(rd_wr_w),
      .mispredict_m(mispredict_m), .dmem_ack(dmem_ack),
      .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .dmem_req(dmem_req), .redirect(redirect),
      .halted(halted), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   function automatic stim_t idle();
      stim_t s;
      s.rst_n = 1'b1;
      s.rs1_d = '0; s.rs2_d = '0; s.rs1_e = '0; s.rs2_e = '0;
      s.rd_e  = '0; s.rd_m  = '0; s.rd_w  = '0;
      s.rd_wr_e = 1'b0; s.mem_rd_e = 1'b0; s.rd_wr_m = 1'b0; s.mem_req_m = 1'b0;
      s.invalid_m = 1'b0; s.rd_wr_w = 1'b0; s.mispredict_m = 1'b0; s.dmem_ack = 1'b0;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst_n = s.rst_n;
      rs1_addr_d = s.rs1_d; rs2_addr_d = s.rs2_d; rs1_addr_e = s.rs1_e; rs2_addr_e = s.rs2_e;
      rd_addr_e = s.rd_e; rd_wr_e = s.rd_wr_e; mem_rd_e = s.mem_rd_e;
      rd_addr_m = s.rd_m; rd_wr_m = s.rd_wr_m; mem_req_m = s.mem_req_m; invalid_m = s.invalid_m;
      rd_addr_w = s.rd_w; rd_wr_w = s.rd_wr_w; mispredict_m = s.mispredict_m; dmem_ack = s.dmem_ack;
   endtask

   task automatic do_reset();
      stim_t s;
      s = idle();
      s.rst_n = 1'b0;
      @(negedge clk);
      apply(s);
      @(negedge clk);
      @(negedge clk);
      apply(idle());
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (obs !== E_RUN) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", obs, E_RUN); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
      checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
   endtask

   task automatic test_load_use();
      stim_t s[5];
      logic [12:0] e[5];
      exp_t x;
      do_reset();
      for (int i = 0; i < 5; i++) s[i] = idle();
      s[0].mem_rd_e = 1; s[0].rd_wr_e = 1; s[0].rd_e = 5; s[0].rs1_d = 5; e[0] = E_LU;
      e[1] = E_RUN;
      s[2].mem_rd_e = 1; s[2].rd_wr_e = 1; s[2].rd_e = 5; s[2].rs1_d = 6; s[2].rs2_d = 5; e[2] = E_LU;
      s[3].mem_rd_e = 1; s[3].rd_wr_e = 1; s[3].rd_e = 0; s[3].rs1_d = 0; e[3] = E_RUN;
      s[4].mem_rd_e = 0; s[4].rd_wr_e = 1; s[4].rd_e = 5; s[4].rs1_d = 5; e[4] = E_RUN;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         apply(s[i]);
         sb.push_back('{tag: $sformatf("load_use[%0d]", i), v: e[i]});
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x.v) begin errors++; $display("FAIL %s: got %b expected %b", x.tag, obs, x.v); end
         if (i == 2) begin
            checks++;
            if (stall_cnt !== 32'd1) begin errors++; $display("FAIL load_use_stall_cnt1: got %0d expected 1", stall_cnt); end
         end
      end
      @(negedge clk); apply(idle()); #1;
      checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL load_use_stall_cnt2: got %0d expected 2", stall_cnt); end
   endtask

   task automatic test_mispredict();
      stim_t s[6];
      logic [12:0] e[6];
      exp_t x;
      do_reset();
      for (int i = 0; i < 6; i++) s[i] = idle();
      s[0].mispredict_m = 1; e[0] = E_FLUSH;
      e[1] = E_RUN;
      s[2].mispredict_m = 1; s[2].mem_rd_e = 1; s[2].rd_wr_e = 1; s[2].rd_e = 3; s[2].rs1_d = 3; e[2] = E_FLUSH;
      s[3].mispredict_m = 1; e[3] = E_FLUSH;
      s[4].mem_rd_e = 1; s[4].rd_wr_e = 1; s[4].rd_e = 3; s[4].rs2_d = 3; e[4] = E_LU;
      e[5] = E_RUN;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         apply(s[i]);
         sb.push_back('{tag: $sformatf("mispredict[%0d]", i), v: e[i]});
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x.v) begin errors++; $display("FAIL %s: got %b expected %b", x.tag, obs, x.v); end
         if (i == 2) begin
            checks++;
            if (flush_cnt !== 32'd1) begin errors++; $display("FAIL mispredict_flush_cnt1: got %0d expected 1", flush_cnt); end
            checks++;
            if (stall_cnt !== 32'd0) begin errors++; $display("FAIL mispredict_stall_cnt0: got %0d expected 0", stall_cnt); end
         end
      end
      @(negedge clk); apply(idle()); #1;
      checks++; if (flush_cnt !== 32'd3) begin errors++; $display("FAIL back_to_back_flush_cnt: got %0d expected 3", flush_cnt); end
      checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL back_to_back_stall_cnt: got %0d expected 1", stall_cnt); end
   endtask

   task automatic test_mem_stall();
      stim_t s[10];
      logic [12:0] e[10];
      exp_t x;
      do_reset();
      for (int i = 0; i < 10; i++) s[i] = idle();
      for (int i = 0; i < 3; i++) begin s[i].mem_req_m = 1; e[i] = E_MSTL; end
      s[3].mem_req_m = 1; s[3].dmem_ack = 1; e[3] = E_ZW;
      e[4] = E_RUN;
      s[5].mem_req_m = 1; s[5].dmem_ack = 1; e[5] = E_ZW;
      e[6] = E_RUN;
      s[7].mem_req_m = 1; s[7].mispredict_m = 1; e[7] = E_MSTL;
      s[8].mem_req_m = 1; s[8].mispredict_m = 1; s[8].dmem_ack = 1; e[8] = E_AFL;
      e[9] = E_RUN;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         apply(s[i]);
         sb.push_back('{tag: $sformatf("mem_stall[%0d]", i), v: e[i]});
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x.v) begin errors++; $display("FAIL %s: got %b expected %b", x.tag, obs, x.v); end
         if (i == 4) begin
            checks++;
            if (stall_cnt !== 32'd3) begin errors++; $display("FAIL mem_stall_cnt3: got %0d expected 3", stall_cnt); end
         end
      end
      @(negedge clk); apply(idle()); #1;
      checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL mem_stall_cnt4: got %0d expected 4", stall_cnt); end
      checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL mem_stall_flush_cnt: got %0d expected 1", flush_cnt); end
   endtask

   task automatic test_timeout();
      stim_t s[8];
      logic [12:0] e[8];
      exp_t x;
      do_reset();
      for (int i = 0; i < 8; i++) begin s[i] = idle(); s[i].mem_req_m = 1; end
      for (int i = 0; i < 5; i++) e[i] = E_MSTL;
      e[5] = E_STOP;
      s[6].dmem_ack = 1; s[6].mispredict_m = 1; e[6] = E_STOP;
      s[7].invalid_m = 1; s[7].mem_rd_e = 1; s[7].rd_wr_e = 1; s[7].rd_e = 2; s[7].rs1_d = 2; e[7] = E_STOP;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         apply(s[i]);
         sb.push_back('{tag: $sformatf("timeout[%0d]", i), v: e[i]});
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x.v) begin errors++; $display("FAIL %s: got %b expected %b", x.tag, obs, x.v); end
         if (i == 4) begin
            checks++;
            if (halted !== 1'b0) begin errors++; $display("FAIL timeout_early_halt: got %b expected 0", halted); end
         end
      end
      @(negedge clk); apply(idle()); #1;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL timeout_halted: got %b expected 1", halted); end
      checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_mem_err: got %b expected 1", mem_err); end
      checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL timeout_stall_cnt: got %0d expected 5", stall_cnt); end
      do_reset();
      #1;
      checks++; if (halted !== 1'b0 || mem_err !== 1'b0) begin
         errors++; $display("FAIL timeout_reset_clear: got halted=%b mem_err=%b expected 0 0", halted, mem_err);
      end
      checks++; if (obs !== E_RUN) begin errors++; $display("FAIL timeout_reset_ctrl: got %b expected %b", obs, E_RUN); end
   endtask

   task automatic test_invalid_halt();
      stim_t s[3];
      logic [12:0] e[3];
      exp_t x;
      do_reset();
      for (int i = 0; i < 3; i++) s[i] = idle();
      s[0].invalid_m = 1; s[0].mispredict_m = 1; e[0] = E_STOP;
      s[1].mispredict_m = 1; e[1] = E_STOP;
      s[2].rd_m = 7; s[2].rd_wr_m = 1; s[2].rs1_e = 7; e[2] = {E_STOP[12:4], 2'b01, 2'b00};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         apply(s[i]);
         sb.push_back('{tag: $sformatf("invalid_halt[%0d]", i), v: e[i]});
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x.v) begin errors++; $display("FAIL %s: got %b expected %b", x.tag, obs, x.v); end
      end
      @(negedge clk); apply(idle()); #1;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL invalid_halted: got %b expected 1", halted); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL invalid_mem_err: got %b expected 0", mem_err); end
      checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL invalid_flush_cnt: got %0d expected 0", flush_cnt); end
      checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL invalid_stall_cnt: got %0d expected 1", stall_cnt); end
   endtask

   task automatic test_forwarding();
      stim_t s[6];
      logic [12:0] e[6];
      exp_t x;
      do_reset();
      for (int i = 0; i < 6; i++) s[i] = idle();
      s[0].rd_m = 7; s[0].rd_wr_m = 1; s[0].rd_w = 7; s[0].rd_wr_w = 1; s[0].rs1_e = 7; s[0].rs2_e = 3;
      e[0] = {E_RUN[12:4], 2'b01, 2'b00};
      s[1].rd_m = 0; s[1].rd_wr_m = 1; s[1].rd_w = 7; s[1].rd_wr_w = 1; s[1].rs1_e = 7;
      e[1] = {E_RUN[12:4], 2'b10, 2'b00};
      s[2].rd_m = 7; s[2].rd_wr_m = 0; s[2].rd_w = 7; s[2].rd_wr_w = 1; s[2].rs1_e = 7;
      e[2] = {E_RUN[12:4], 2'b10, 2'b00};
      s[3].rd_m = 0; s[3].rd_wr_m = 1; s[3].rd_w = 0; s[3].rd_wr_w = 1; s[3].rs1_e = 0; s[3].rs2_e = 0;
      e[3] = {E_RUN[12:4], 2'b00, 2'b00};
      s[4].rd_m = 9; s[4].rd_wr_m = 1; s[4].rd_w = 9; s[4].rd_wr_w = 1; s[4].rs1_e = 9; s[4].rs2_e = 9;
      e[4] = {E_RUN[12:4], 2'b01, 2'b01};
      s[5].rd_m = 4; s[5].rd_wr_m = 1; s[5].rd_w = 12; s[5].rd_wr_w = 1; s[5].rs1_e = 4; s[5].rs2_e = 12;
      e[5] = {E_RUN[12:4], 2'b01, 2'b10};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         apply(s[i]);
         sb.push_back('{tag: $sformatf("forwarding[%0d]", i), v: e[i]});
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x.v) begin errors++; $display("FAIL %s: got %b expected %b", x.tag, obs, x.v); end
      end
   endtask

   task automatic test_reset_mid_wait();
      stim_t s[4];
      logic [12:0] e[4];
      exp_t x;
      do_reset();
      for (int i = 0; i < 4; i++) s[i] = idle();
      s[0].mem_req_m = 1; e[0] = E_MSTL;
      s[1].mem_req_m = 1; e[1] = E_MSTL;
      s[2].rst_n = 0; e[2] = E_MSTL;
      e[3] = E_RUN;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         apply(s[i]);
         sb.push_back('{tag: $sformatf("reset_mid_wait[%0d]", i), v: e[i]});
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x.v) begin errors++; $display("FAIL %s: got %b expected %b", x.tag, obs, x.v); end
      end
      @(negedge clk); apply(idle()); #1;
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_mid_wait_stall_cnt: got %0d expected 0", stall_cnt); end
   endtask

   initial begin
      apply(idle());
      rst_n = 1'b0;
      test_reset();
      test_load_use();
      test_mispredict();
      test_mem_stall();
      test_timeout();
      test_invalid_halt();
      test_forwarding();
      test_reset_mid_wait();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
